sorted_matrix_streamer: RTL
===========================

// Module: sorted_matrix_streamer
// PURPOSE
//  Consumer end of the sorter's flattened matrix bus. Captures one N x N sorted matrix (N*N*WIDTH bus)
//  on a load strobe and streams it out one element per handshake (valid/ready), row-major or snake order.
//  Optionally checks that the streamed sequence is non-decreasing. Sits between the mesh sorter and a
//  serial sink (UART/FIFO/scoreboard).
// PARAMETERS
//  N      8   matrix dimension; N >= 2
//  WIDTH  8   element width in bits
//  SNAKE  0   0: row-major order; 1: snake order (odd rows read right-to-left)
// PORTS
//  clk           input   1              rising-edge clock
//  reset         input   1              asynchronous, active-low reset
//  load          input   1              capture strobe for matrix_in
//  matrix_in     input   N*N*WIDTH      element (r,c) at bits [(r*N+c)*WIDTH +: WIDTH]
//  busy          output  1              high while a matrix is held and not fully streamed
//  out_data      output  WIDTH          current element
//  out_valid     output  1              out_data valid
//  out_ready     input   1              sink accepts out_data
//  out_index     output  $clog2(N*N)    stream position 0..N*N-1 of out_data
//  out_last      output  1              high with the final element (position N*N-1)
//  done          output  1              one-cycle pulse after the last element is accepted
//  order_error   output  1              sticky: stream was not non-decreasing
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE; matrix buffer, out_data, out_index, counters = 0;
//    busy, out_valid, out_last, done, order_error = 0. Reset mid-stream aborts; no partial resume.
//  - FSM IDLE -> STREAM -> DONE -> IDLE.
//    IDLE: load==1 captures matrix_in into the internal buffer and enters STREAM; busy=1 next cycle.
//    STREAM: out_valid=1 from the cycle after load (latency 1); first element is position 0.
//      Handshake = out_valid && out_ready. On handshake, advance to next position; next element valid in
//      the following cycle (one element/cycle under continuous out_ready).
//      With out_valid=1 and out_ready=0, out_data/out_index/out_last hold stable.
//      Handshake at position N*N-1 (out_last=1) enters DONE; out_valid drops next cycle.
//    DONE: one cycle; done=1, busy=0, out_valid=0; returns to IDLE.
//  - load is ignored in STREAM and DONE; buffer is not overwritten mid-stream. Earliest reload is the
//    IDLE cycle after DONE.
//  - Position p -> row r=p/N, col k=p%N. SNAKE=0: element (r,k). SNAKE=1: element (r,k) for even r,
//    (r,N-1-k) for odd r. out_index always reports p, not the physical column.
//  - Order check: compare each accepted element with the previously accepted one in the same matrix
//    (unsigned). prev > cur sets order_error, which stays set through DONE/IDLE. The next accepted load
//    clears it. The first element of a matrix is never compared.
//  - Counter is $clog2(N*N) bits; no wrap past N*N-1; equal values are legal (non-decreasing).
// CONFIGURATION
//  STREAMER_ORDER_CHECK_EN defined: order checker present as above.
//  Not defined: comparator and previous-element register removed; order_error tied to 0.
//  All other behaviour identical.
// TESTING  (bench: N=4, WIDTH=8, STREAMER_ORDER_CHECK_EN defined unless noted)
//  1 matrix 0..15 row-major, SNAKE=0, out_ready=1 -> 16 handshakes on consecutive cycles, data 0..15,
//    out_last at 15, done pulse one cycle later, order_error=0.
//  2 same matrix, SNAKE=1 -> data 0,1,2,3,7,6,5,4,8,9,10,11,15,14,13,12; out_index 0..15; order_error=1.
//  3 out_ready toggled pseudo-randomly -> data/index held stable while stalled; sequence still 0..15.
//  4 element 9 set to 3, rest sorted -> order_error rises after position 9 is accepted, holds after
//    done; next load clears it.
//  5 load pulsed at position 5 with a different matrix -> ignored; original stream completes; reset
//    asserted at position 7 -> all outputs 0 immediately; busy=0.
//  6 macro undefined, unsorted input -> order_error stays 0; stream order unchanged.

Source files
------------

// File: rtl/sorted_matrix_streamer_if.sv
// Element stream from sorted_matrix_streamer to a serial sink.
// The master drives data, index and last along with valid. The slave drives ready.
interface sorted_matrix_streamer_if #(
    parameter int N     = 8,
    parameter int WIDTH = 8
);
    localparam int IW = $clog2(N*N);

    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [IW-1:0]    out_index;
    logic             out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/sorted_matrix_streamer.sv
// sorted_matrix_streamer: captures an N x N matrix on load and streams it one element
// per valid/ready handshake, in row-major order or in snake order.
// Optional feature: define STREAMER_ORDER_CHECK_EN to add the sticky non-decreasing
// order checker. Without the macro, order_error is tied low.
module sorted_matrix_streamer #(
    parameter int N     = 8,
    parameter int WIDTH = 8,
    parameter int SNAKE = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [N*N*WIDTH-1:0]   matrix_in,
    output logic                   busy,
    output logic                   done,
    output logic                   order_error,
    sorted_matrix_streamer_if.master strm
);
    localparam int unsigned IW = $clog2(N*N);
    localparam int unsigned NU = N;
    localparam logic [IW-1:0] LAST_POS = IW'(N*N-1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [N*N*WIDTH-1:0]   mat_q, mat_d;
    logic [IW-1:0]          pos_q, pos_d;
    logic [WIDTH-1:0]       cur_elem;
    logic                   hs;
    int unsigned            sel_row;
    int unsigned            sel_col;

    // Map stream position to the buffered element; odd rows are mirrored in snake order.
    always_comb begin
        sel_row = 32'(pos_q) / NU;
        sel_col = 32'(pos_q) % NU;
        if (SNAKE != 0 && sel_row[0]) begin
            sel_col = NU - 1 - sel_col;
        end
        cur_elem = mat_q[(sel_row*NU + sel_col)*WIDTH +: WIDTH];
    end

    // Stream outputs are decoded from the registered state and position.
    always_comb begin
        strm.out_valid = (state_q == S_STREAM);
        strm.out_data  = cur_elem;
        strm.out_index = pos_q;
        strm.out_last  = (state_q == S_STREAM) && (pos_q == LAST_POS);
        busy           = (state_q == S_STREAM);
        done           = (state_q == S_DONE);
        hs             = (state_q == S_STREAM) && strm.out_ready;
    end

    // Next-state: capture on load in IDLE, advance on handshake, one DONE cycle.
    always_comb begin
        state_d = state_q;
        mat_d   = mat_q;
        pos_d   = pos_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    mat_d   = matrix_in;
                    pos_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (hs) begin
                    if (pos_q == LAST_POS) begin
                        state_d = S_DONE;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, buffer and position registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mat_q   <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            mat_q   <= mat_d;
            pos_q   <= pos_d;
        end
    end

`ifdef STREAMER_ORDER_CHECK_EN
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             err_q, err_d;

    // Compare each accepted element against the previous one; a new load clears the flag.
    always_comb begin
        prev_d = prev_q;
        err_d  = err_q;
        if (state_q == S_IDLE && load) begin
            err_d = 1'b0;
        end else if (hs) begin
            prev_d = cur_elem;
            if (pos_q != '0 && prev_q > cur_elem) begin
                err_d = 1'b1;
            end
        end
    end

    // Order checker registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= '0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            err_q  <= err_d;
        end
    end

    assign order_error = err_q;
`else
    assign order_error = 1'b0;
`endif
endmodule
